npu_fpga_sram_pipe: RTL

Parametrised FPGA block-RAM SRAM for NPU local buffers. It generalises the fixed 32-bit single-stage SRAM with three additions: configurable data width, configurable read latency (1 or 2 cycles) with a read-valid strobe, and a hardware zero-fill sequencer that runs after reset. Used as weight, activation and scratch storage behind the NPU's local memory-mapped SRAM port.

---
 rtl/npu_fpga_sram_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/npu_fpga_sram_pipe.sv
// Byte-lane block-RAM buffer with post-reset zero-fill sequencer and 1- or 2-cycle read latency.
// Optional macro NPU_SRAM_WR_FWD_EN turns same-address collisions into write-first reads.
module npu_fpga_sram_pipe #(
    parameter int unsigned AW     = 10,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [AW-1:0]     ADDR,
    input  logic [DW-1:0]     WDATA,
    input  logic [DW/8-1:0]   WREN,
    input  logic              CS,
    output logic [DW-1:0]     RDATA,
    output logic              RVALID,
    output logic              READY
);

    localparam int unsigned NB    = DW / 8;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    state_e            state_q;
    logic [AW-1:0]     fill_cnt_q;
    logic              ready_q;

    logic              acc;
    logic [NB-1:0]     mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_wdata;

    logic [DW-1:0]     mem [DEPTH];
    logic [DW-1:0]     mem_rd_q;
    logic              v1_q;
    logic [DW-1:0]     stage1_data;
    logic              out_valid;
    logic [DW-1:0]     out_data;

    // An access is only accepted once the fill is done and not on a reset edge.
    always_comb begin
        acc = CS & ready_q & ~RESET;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StInit;
            fill_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    fill_cnt_q <= fill_cnt_q + AW'(1);
                    if (&fill_cnt_q) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

    // Single write port shared between the fill sequencer and user writes.
    always_comb begin
        mem_we    = '0;
        mem_waddr = ADDR;
        mem_wdata = WDATA;
        if (!RESET && state_q == StInit) begin
            mem_we    = '1;
            mem_waddr = fill_cnt_q;
            mem_wdata = '0;
        end else if (acc) begin
            mem_we = WREN;
        end
    end

    // Read and write share the edge; the non-blocking read gives read-first data.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < int'(NB); k++) begin
            if (mem_we[k]) begin
                mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
        if (acc) begin
            mem_rd_q <= mem[ADDR];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= acc;
        end
    end

`ifdef NPU_SRAM_WR_FWD_EN
    logic [NB-1:0] byp_mask_q;
    logic [DW-1:0] byp_data_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            byp_mask_q <= '0;
            byp_data_q <= '0;
        end else if (acc) begin
            byp_mask_q <= WREN;
            byp_data_q <= WDATA;
        end
    end

    // Lanes written on the accepting edge take the new data instead of the array output.
    always_comb begin
        stage1_data = mem_rd_q;
        for (int k = 0; k < int'(NB); k++) begin
            if (byp_mask_q[k]) begin
                stage1_data[8*k +: 8] = byp_data_q[8*k +: 8];
            end
        end
    end
`else
    always_comb begin
        stage1_data = mem_rd_q;
    end
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          v2_q;
            logic [DW-1:0] d2_q;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    d2_q <= v1_q ? stage1_data : '0;
                end
            end

            assign out_valid = v2_q;
            assign out_data  = d2_q;
        end else begin : g_lat1
            assign out_valid = v1_q;
            assign out_data  = stage1_data;
        end
    endgenerate

    always_comb begin
        RVALID = out_valid;
        RDATA  = out_valid ? out_data : '0;
        READY  = ready_q;
    end

endmodule
